stg1if: RTL and testbench
=========================

# stg1if

Instruction-fetch stage of the pipeline. It holds the fetch PC and drives a single-outstanding req/ack instruction-memory port. A 2-entry fetch buffer decouples memory latency from the downstream IF/ID latch (`stg2id`), whose `iw_pc`/`iw_instr` inputs are fed directly from this block's `ow_pc`/`ow_instr`. It also handles branch redirects, including discarding a fetch already in flight.

## Interface
Parameters:
- `RESET_PC`, default `SIZE_ADDR'b0`: fetch address after reset.
- `PC_STEP`, default 1: PC increment per fetched word (word-addressed memory).

Ports:
- `iw_clk`, in, 1: the single clock; all state updates on its rising edge.
- `iw_rst`, in, 1: reset, asynchronous, active-high.
- `iw_stall`, in, 1: hazard unit; downstream does not accept this cycle.
- `iw_redirect`, in, 1: branch taken or jump; one-cycle pulse.
- `iw_redirect_pc`, in, `HBIT_ADDR+1`: redirect target.
- `ow_imem_req`, out, 1: memory request.
- `ow_imem_addr`, out, `HBIT_ADDR+1`: request address.
- `iw_imem_ack`, in, 1: response valid, meaningful only while `ow_imem_req` is 1.
- `iw_imem_data`, in, `HBIT_DATA+1`: instruction word, valid with `iw_imem_ack`.
- `ow_pc`, out, `HBIT_ADDR+1`: PC of the presented instruction.
- `ow_instr`, out, `HBIT_DATA+1`: presented instruction, or `INSTR_NOP` when none.
- `ow_valid`, out, 1: `ow_instr` is a real fetched instruction.

## Operation
- Registers:
  - `r_fetch_pc`: address of the current/next request.
  - `r_target`: saved redirect PC.
  - state: `S_RUN` or `S_DROP`.
  - 2-entry buffer of {pc, instr} with `r_count` 0..2.
- Memory protocol:
  - `ow_imem_addr` = `r_fetch_pc`.
  - Once `ow_imem_req` rises, req and addr stay stable until the ack cycle.
  - The ack and its data arrive combinationally in the ack cycle.
  - At most one request is outstanding.
- `ow_imem_req` = !`iw_rst` && (`S_DROP` || `r_count` < 2).
  - This is stable by construction: `r_count` cannot rise without an ack, and flush/pop only lower it.
- `S_RUN`, request acked, no redirect:
  - Push {`r_fetch_pc`, `iw_imem_data`}.
  - `r_fetch_pc` += `PC_STEP`, modulo 2^`SIZE_ADDR`; all-ones wraps to 0.
- Pop: when `r_count` > 0, !`iw_stall` and !`iw_redirect`. Push and pop in the same cycle leave `r_count` unchanged.
- Redirect in `S_RUN`:
  - Flush the buffer (`r_count` = 0); any same-cycle pop or push is ignored.
  - If req is pending without ack this cycle: `r_target` = `iw_redirect_pc`, go to `S_DROP`.
  - Else (ack this cycle, or no req): `r_fetch_pc` = `iw_redirect_pc` and stay in `S_RUN`. Same-cycle ack data is discarded.
- `S_DROP`:
  - req held at the old addr; the buffer stays empty.
  - On ack: discard the data, `r_fetch_pc` = `r_target`, go to `S_RUN`.
  - A new redirect in `S_DROP` overwrites `r_target`. If the ack arrives in that same cycle, the new `iw_redirect_pc` is loaded instead.
- Outputs, combinational from the buffer head:
  - `ow_valid` = (`r_count` != 0).
  - Empty buffer: `ow_instr` = `INSTR_NOP` (all zeros), `ow_pc` = 0.
- Stall with an empty buffer has no effect. Stall and redirect together: redirect wins.

## Timing
- Reset values while `iw_rst` is high:
  - `r_fetch_pc` = `RESET_PC`, state `S_RUN`, `r_count` = 0.
  - `ow_imem_req` = 0, `ow_imem_addr` = `RESET_PC`.
  - `ow_valid` = 0, `ow_instr` = `INSTR_NOP`, `ow_pc` = 0.
- Reset asserted mid-operation: all of the above take effect immediately. An in-flight memory response is abandoned, and the memory must tolerate a dropped req.
- After reset deassert: req rises in the first cycle. With ack in that cycle, the instruction is on `ow_instr` with `ow_valid` = 1 in the next cycle.
- Latency ack→`ow_instr` is 1 cycle; throughput is 1 instr/cycle with zero-wait memory.
- Redirect at cycle N:
  - `ow_valid` = 0 at N+1.
  - If no drop is needed, req to the target at N+1. With ack at N+1, the target instruction is valid at N+2.
  - If a drop is needed, add the remaining latency of the old request.
- Buffer full (`r_count` = 2) with stall: req = 0 and the buffer holds. Unstall pops one entry; req reasserts the next cycle.

## Structure
- Shared header `src2/sizes.vh`: the existing `SIZE_`/`HBIT_` ADDR/DATA macros.
- Add `INSTR_NOP` to `src2/sizes.vh`, so `stg2id`'s reset value and this block's bubble agree.
- State encodings are local to this block.
- One sub-module, `stg1if_fifo`:
  - 2-entry {pc, instr} buffer with push/pop/flush, count, and head outputs.
  - Flush has priority over push and pop.

## Test plan
- Reset with `RESET_PC` = 0x10: req = 0 during reset, addr = 0x10 after. Zero-wait ack returns 0xA1, then `ow_pc` = 0x10, `ow_instr` = 0xA1, `ow_valid` = 1 one cycle later.
- Zero-wait stream from 0, no stall: `ow_pc` shows 0, 1, 2, 3 on consecutive cycles.
- Stall held 4 cycles in the stream: `r_count` saturates at 2, req drops, no instruction is lost or duplicated, and the sequence resumes in order after release.
- 3-cycle memory latency, redirect to 0x40 during the 2nd wait cycle: enters `S_DROP`, the old data is discarded, the next req addr = 0x40, and the first valid `ow_pc` is 0x40.
- Redirect to 0x80 in the same cycle as an ack and a pop: the acked data is dropped, next cycle `ow_valid` = 0 and `ow_imem_addr` = 0x80.
- `RESET_PC` = all-ones: after one ack, `ow_imem_addr` wraps to 0. Then assert `iw_rst` mid-latency: outputs return to their reset values immediately.

Source files
------------

// File: rtl/stg1if_pkg.sv
// stg1if_pkg -- shared definitions for the instruction-fetch stage.
//
// Holds the address/data sizes (mirroring the SIZE_/HBIT_ ADDR/DATA
// macros used across the pipeline), the bubble instruction INSTR_NOP
// that the downstream IF/ID latch also resets to, the fetch FSM state
// encoding, the debug view of that FSM, and a PC-advance helper.
package stg1if_pkg;

    localparam int SIZE_ADDR = 16;
    localparam int SIZE_DATA = 32;
    localparam int HBIT_ADDR = SIZE_ADDR - 1;
    localparam int HBIT_DATA = SIZE_DATA - 1;

    // Bubble word: all zeros, identical to stg2id's reset value.
    localparam logic [HBIT_DATA:0] INSTR_NOP = '0;

    // S_RUN : normal fetching.
    // S_DROP: an old request is still in flight after a redirect; its
    //         response is thrown away before fetching from r_target.
    typedef enum logic {
        S_RUN  = 1'b0,
        S_DROP = 1'b1
    } state_t;

    typedef struct packed {
        state_t     state;
        logic [1:0] count;
    } dbg_t;

    // Advance a fetch PC; the sum is truncated so all-ones wraps to 0.
    function automatic logic [HBIT_ADDR:0] pc_next(input logic [HBIT_ADDR:0] pc,
                                                   input int step);
        logic [HBIT_ADDR:0] inc;
        inc = step[HBIT_ADDR:0];
        return pc + inc;
    endfunction

endpackage

// File: rtl/stg1if_if.sv
// stg1if_if -- bus bundle of the instruction-fetch stage.
//
// Groups the instruction-memory port and the presented-instruction
// outputs that feed stg2id.
//   master : the fetch stage (drives req/addr and pc/instr/valid)
//   slave  : memory + downstream side (drives ack/data)
//
// Handshake: ow_imem_req rises with ow_imem_addr and both stay stable
// until the cycle in which iw_imem_ack is 1; iw_imem_data is valid only
// in that cycle and ack is ignored while req is 0. At most one request
// is outstanding. ow_valid marks ow_pc/ow_instr as a real instruction;
// the downstream takes it in any cycle without a stall.
interface stg1if_if;
    import stg1if_pkg::*;

    logic               ow_imem_req;
    logic [HBIT_ADDR:0] ow_imem_addr;
    logic               iw_imem_ack;
    logic [HBIT_DATA:0] iw_imem_data;
    logic [HBIT_ADDR:0] ow_pc;
    logic [HBIT_DATA:0] ow_instr;
    logic               ow_valid;

    modport master (
        output ow_imem_req,
        output ow_imem_addr,
        input  iw_imem_ack,
        input  iw_imem_data,
        output ow_pc,
        output ow_instr,
        output ow_valid
    );

    modport slave (
        input  ow_imem_req,
        input  ow_imem_addr,
        output iw_imem_ack,
        output iw_imem_data,
        input  ow_pc,
        input  ow_instr,
        input  ow_valid
    );

endinterface

// File: rtl/stg1if_fifo.sv
// stg1if_fifo -- 2-entry {pc, instr} fetch buffer.
//
// Ports:
//   iw_clk, iw_rst        clock, asynchronous active-high reset
//   iw_push, iw_pc/instr  write one entry
//   iw_pop                drop the head entry (ignored when empty)
//   iw_flush              empty the buffer; beats push and pop
//   ow_count              occupancy 0..2
//   ow_head_pc/instr      head entry (undefined contents when empty)
module stg1if_fifo
    import stg1if_pkg::*;
(
    input  logic               iw_clk,
    input  logic               iw_rst,
    input  logic               iw_push,
    input  logic               iw_pop,
    input  logic               iw_flush,
    input  logic [HBIT_ADDR:0] iw_pc,
    input  logic [HBIT_DATA:0] iw_instr,
    output logic [1:0]         ow_count,
    output logic [HBIT_ADDR:0] ow_head_pc,
    output logic [HBIT_DATA:0] ow_head_instr
);

    logic [HBIT_ADDR:0] r_mem_pc    [2];
    logic [HBIT_DATA:0] r_mem_instr [2];
    logic               r_rd_ptr;
    logic               r_wr_ptr;
    logic [1:0]         r_count;
    logic               w_do_pop;
    logic               w_do_push;

    assign w_do_pop  = iw_pop && (r_count != 2'd0) && !iw_flush;
    // A push into a full buffer is only accepted when a pop frees a slot.
    assign w_do_push = iw_push && ((r_count != 2'd2) || w_do_pop) && !iw_flush;

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (iw_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone says what is meaningful.
    always_ff @(posedge iw_clk) begin
        if (w_do_push) begin
            r_mem_pc[r_wr_ptr]    <= iw_pc;
            r_mem_instr[r_wr_ptr] <= iw_instr;
        end
    end

    assign ow_count      = r_count;
    assign ow_head_pc    = r_mem_pc[r_rd_ptr];
    assign ow_head_instr = r_mem_instr[r_rd_ptr];

endmodule

// File: rtl/stg1if.sv
// stg1if -- instruction-fetch stage.
//
// Holds the fetch PC, drives a single-outstanding req/ack instruction
// memory port, and buffers up to two fetched words ahead of the IF/ID
// latch. Branch redirects flush the buffer; a request already in flight
// when a redirect arrives is completed and its data discarded (S_DROP).
//
// Ports:
//   iw_clk, iw_rst   clock, asynchronous active-high reset
//   iw_stall         downstream does not accept this cycle
//   iw_redirect      one-cycle branch/jump pulse, target in iw_redirect_pc
//   port             stg1if_if master: imem req/addr/ack/data and the
//                    presented ow_pc/ow_instr/ow_valid
//   ow_dbg           FSM state and buffer occupancy
module stg1if
    import stg1if_pkg::*;
#(
    parameter logic [HBIT_ADDR:0] RESET_PC = '0,
    parameter int                 PC_STEP  = 1
) (
    input  logic               iw_clk,
    input  logic               iw_rst,
    input  logic               iw_stall,
    input  logic               iw_redirect,
    input  logic [HBIT_ADDR:0] iw_redirect_pc,
    stg1if_if.master           port,
    output dbg_t               ow_dbg
);

    state_t             r_state;
    logic [HBIT_ADDR:0] r_fetch_pc;
    logic [HBIT_ADDR:0] r_target;

    logic [1:0]         w_count;
    logic [HBIT_ADDR:0] w_head_pc;
    logic [HBIT_DATA:0] w_head_instr;
    logic               w_req;
    logic               w_ack;
    logic               w_push;
    logic               w_pop;
    logic               w_valid;

    // Stable by construction: count only rises on an ack, and flush/pop
    // only lower it, so a raised req cannot fall before its ack.
    assign w_req   = !iw_rst && ((r_state == S_DROP) || (w_count != 2'd2));
    assign w_ack   = w_req && port.iw_imem_ack;
    assign w_push  = (r_state == S_RUN) && w_ack && !iw_redirect;
    assign w_pop   = !iw_stall && !iw_redirect;
    assign w_valid = (w_count != 2'd0);

    stg1if_fifo u_fifo (
        .iw_clk        (iw_clk),
        .iw_rst        (iw_rst),
        .iw_push       (w_push),
        .iw_pop        (w_pop),
        .iw_flush      (iw_redirect),
        .iw_pc         (r_fetch_pc),
        .iw_instr      (port.iw_imem_data),
        .ow_count      (w_count),
        .ow_head_pc    (w_head_pc),
        .ow_head_instr (w_head_instr)
    );

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_state    <= S_RUN;
            r_fetch_pc <= RESET_PC;
            r_target   <= RESET_PC;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (iw_redirect) begin
                        if (w_req && !w_ack) begin
                            // Old request still pending: remember the
                            // target and wait for its response to drop it.
                            r_target <= iw_redirect_pc;
                            r_state  <= S_DROP;
                        end else begin
                            r_fetch_pc <= iw_redirect_pc;
                        end
                    end else if (w_ack) begin
                        r_fetch_pc <= pc_next(r_fetch_pc, PC_STEP);
                    end
                end
                S_DROP: begin
                    if (w_ack) begin
                        // A redirect landing with the ack is newer than r_target.
                        r_fetch_pc <= iw_redirect ? iw_redirect_pc : r_target;
                        r_state    <= S_RUN;
                    end else if (iw_redirect) begin
                        r_target <= iw_redirect_pc;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign port.ow_imem_req  = w_req;
    assign port.ow_imem_addr = r_fetch_pc;
    assign port.ow_valid     = w_valid;
    assign port.ow_pc        = w_valid ? w_head_pc : '0;
    assign port.ow_instr     = w_valid ? w_head_instr : INSTR_NOP;

    assign ow_dbg.state = r_state;
    assign ow_dbg.count = w_count;

endmodule

// File: tb/tb_stg1if.sv
// tb_stg1if -- bench for the instruction-fetch stage.
//
// Main DUT uses RESET_PC = 0x10 with a variable-latency memory model.
// The expected instruction stream is "consecutive PCs from the last
// reset/redirect target, each carrying mem_word(pc)"; a monitor pops it
// whenever the DUT hands an instruction downstream. A second DUT with
// RESET_PC = all-ones covers PC wrap and asynchronous reset.
module tb_stg1if;
    import stg1if_pkg::*;

    localparam int                 AW        = SIZE_ADDR;
    localparam int                 DW        = SIZE_DATA;
    localparam logic [HBIT_ADDR:0] PC_A      = 16'h0010;
    localparam logic [HBIT_ADDR:0] PC_W      = '1;
    localparam int                 EXP_DEPTH = 400;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    dbg_t          dbg;

    logic          rst_w;
    logic          w_ack;
    dbg_t          dbg_w;

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] sb_e;

    int            lat_min = 0;
    int            lat_max = 0;
    logic          mem_busy = 1'b0;
    int            mem_left = 0;
    logic [AW-1:0] mem_addr = '0;

    stg1if_if bus();
    stg1if_if bus_w();

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    stg1if #(.RESET_PC(PC_A), .PC_STEP(1)) dut (
        .iw_clk         (clk),
        .iw_rst         (rst),
        .iw_stall       (stall),
        .iw_redirect    (redirect),
        .iw_redirect_pc (redirect_pc),
        .port           (bus),
        .ow_dbg         (dbg)
    );

    stg1if #(.RESET_PC(PC_W), .PC_STEP(1)) dut_w (
        .iw_clk         (clk),
        .iw_rst         (rst_w),
        .iw_stall       (1'b0),
        .iw_redirect    (1'b0),
        .iw_redirect_pc ('0),
        .port           (bus_w),
        .ow_dbg         (dbg_w)
    );

    // ---------------- helpers ----------------
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {~a, a} ^ 32'h0000_00B1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_stream(input logic [AW-1:0] start);
        logic [AW-1:0] p;
        exp_q.delete();
        for (int i = 0; i < EXP_DEPTH; i++) begin
            p = start + AW'(i);
            exp_q.push_back({p, mem_word(p)});
        end
    endtask

    // ---------------- memory models ----------------
    assign bus_w.iw_imem_ack  = bus_w.ow_imem_req & w_ack;
    assign bus_w.iw_imem_data = mem_word(bus_w.ow_imem_addr);

    initial begin
        bus.iw_imem_ack  = 1'b0;
        bus.iw_imem_data = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst || !bus.ow_imem_req) begin
                mem_busy         = 1'b0;
                bus.iw_imem_ack  = 1'b0;
            end else begin
                if (!mem_busy) begin
                    mem_busy = 1'b1;
                    mem_left = $urandom_range(lat_max, lat_min);
                    mem_addr = bus.ow_imem_addr;
                end else begin
                    check("imem_addr_stable", 64'(bus.ow_imem_addr), 64'(mem_addr));
                end
                if (mem_left == 0) begin
                    bus.iw_imem_ack  = 1'b1;
                    bus.iw_imem_data = mem_word(bus.ow_imem_addr);
                    mem_busy         = 1'b0;
                end else begin
                    bus.iw_imem_ack  = 1'b0;
                    bus.iw_imem_data = 32'hDEAD_BEEF;
                    mem_left--;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ow_valid && !stall && !redirect) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 64'(exp_q.size()), 64'(1));
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_pc", 64'(bus.ow_pc), 64'(sb_e[AW+DW-1:DW]));
                    check("sb_instr", 64'(bus.ow_instr), 64'(sb_e[DW-1:0]));
                end
            end else if (!bus.ow_valid) begin
                check("bubble_pc", 64'(bus.ow_pc), 64'(0));
                check("bubble_instr", 64'(bus.ow_instr), 64'(INSTR_NOP));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        rst_w = 1'b1; w_ack = 1'b0;
        lat_min = 0; lat_max = 0;
        load_stream(PC_A);

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", 64'(bus.ow_imem_req), 64'(0));
        check("rst_addr", 64'(bus.ow_imem_addr), 64'(PC_A));
        check("rst_valid", 64'(bus.ow_valid), 64'(0));
        check("rst_instr", 64'(bus.ow_instr), 64'(INSTR_NOP));
        check("rst_pc", 64'(bus.ow_pc), 64'(0));
        check("rst_count", 64'(dbg.count), 64'(0));
        check("rst_state", 64'(dbg.state), 64'(S_RUN));

        // First fetch after reset, zero-wait memory
        cyc(); rst = 1'b0;
        @(negedge clk);
        check("first_req", 64'(bus.ow_imem_req), 64'(1));
        check("first_addr", 64'(bus.ow_imem_addr), 64'(PC_A));
        check("first_ack", 64'(bus.iw_imem_ack), 64'(1));
        cyc();
        @(negedge clk);
        check("first_valid", 64'(bus.ow_valid), 64'(1));
        check("first_pc", 64'(bus.ow_pc), 64'(16'h0010));
        check("first_instr", 64'(bus.ow_instr), 64'(32'hFFEF_00A1));

        // Redirect to 0 (ack in same cycle, no drop), then stream 0,1,2,3
        cyc(); redirect = 1'b1; redirect_pc = 16'h0000; load_stream(16'h0000);
        @(negedge clk);
        check("redir0_ack_same_cycle", 64'(bus.iw_imem_ack), 64'(1));
        cyc(); redirect = 1'b0;
        @(negedge clk);
        check("redir0_valid_low", 64'(bus.ow_valid), 64'(0));
        check("redir0_addr", 64'(bus.ow_imem_addr), 64'(0));
        check("redir0_req", 64'(bus.ow_imem_req), 64'(1));
        for (int i = 0; i < 4; i++) begin
            cyc();
            @(negedge clk);
            check("stream_valid", 64'(bus.ow_valid), 64'(1));
            check("stream_pc", 64'(bus.ow_pc), 64'(i));
        end

        // Stall held 4 cycles: buffer saturates, req drops, resumes in order
        cyc(); stall = 1'b1;
        cyc();
        @(negedge clk);
        check("stall_count_sat", 64'(dbg.count), 64'(2));
        check("stall_req_low", 64'(bus.ow_imem_req), 64'(0));
        cyc();
        cyc();
        @(negedge clk);
        check("stall_count_hold", 64'(dbg.count), 64'(2));
        check("stall_req_hold", 64'(bus.ow_imem_req), 64'(0));
        check("stall_valid", 64'(bus.ow_valid), 64'(1));
        cyc(); stall = 1'b0;
        @(negedge clk);
        check("unstall_req_still_low", 64'(bus.ow_imem_req), 64'(0));
        cyc();
        @(negedge clk);
        check("unstall_req_back", 64'(bus.ow_imem_req), 64'(1));

        // 3-wait-cycle memory, redirect to 0x40 during the 2nd wait cycle
        cyc(); stall = 1'b1;
        cyc(); lat_min = 3; lat_max = 3;
        cyc(); stall = 1'b0;
        cyc();
        cyc(); redirect = 1'b1; redirect_pc = 16'h0040; load_stream(16'h0040);
        @(negedge clk);
        check("drop_pending_no_ack", 64'(bus.iw_imem_ack), 64'(0));
        cyc(); redirect = 1'b0;
        @(negedge clk);
        check("drop_state", 64'(dbg.state), 64'(S_DROP));
        check("drop_addr_held", 64'(bus.ow_imem_addr), 64'(16'h0008));
        check("drop_valid_low", 64'(bus.ow_valid), 64'(0));
        cyc();
        @(negedge clk);
        check("drop_old_ack", 64'(bus.iw_imem_ack), 64'(1));
        cyc();
        @(negedge clk);
        check("drop_exit_state", 64'(dbg.state), 64'(S_RUN));
        check("drop_new_addr", 64'(bus.ow_imem_addr), 64'(16'h0040));
        for (int i = 0; i < 10; i++) begin
            if (bus.ow_valid) break;
            cyc();
            @(negedge clk);
        end
        check("drop_first_valid_seen", 64'(bus.ow_valid), 64'(1));
        check("drop_first_pc", 64'(bus.ow_pc), 64'(16'h0040));

        // Redirect to 0x80 together with an ack and a pop
        lat_min = 0; lat_max = 0;
        repeat (8) cyc();
        redirect = 1'b1; redirect_pc = 16'h0080; load_stream(16'h0080);
        @(negedge clk);
        check("r80_ack", 64'(bus.iw_imem_ack), 64'(1));
        check("r80_pop_candidate", 64'(bus.ow_valid), 64'(1));
        cyc(); redirect = 1'b0;
        @(negedge clk);
        check("r80_valid_low", 64'(bus.ow_valid), 64'(0));
        check("r80_addr", 64'(bus.ow_imem_addr), 64'(16'h0080));

        // Randomized traffic: stalls, redirects, latency 0..3
        lat_min = 0; lat_max = 3;
        for (int c = 0; c < 2000; c++) begin
            cyc();
            stall = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 6 || exp_q.size() < 50) begin
                redirect    = 1'b1;
                redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFD : AW'($urandom_range(0, 16'hFFFF));
                load_stream(redirect_pc);
            end else begin
                redirect = 1'b0;
            end
        end
        cyc(); stall = 1'b0; redirect = 1'b0;
        repeat (10) cyc();

        // Second DUT: RESET_PC all-ones wraps, then async reset mid-request
        @(negedge clk);
        check("w_rst_req", 64'(bus_w.ow_imem_req), 64'(0));
        check("w_rst_addr", 64'(bus_w.ow_imem_addr), 64'(PC_W));
        cyc(); rst_w = 1'b0; w_ack = 1'b1;
        @(negedge clk);
        check("w_first_req", 64'(bus_w.ow_imem_req), 64'(1));
        check("w_first_addr", 64'(bus_w.ow_imem_addr), 64'(PC_W));
        cyc(); w_ack = 1'b0;
        @(negedge clk);
        check("w_wrap_addr", 64'(bus_w.ow_imem_addr), 64'(0));
        check("w_valid", 64'(bus_w.ow_valid), 64'(1));
        check("w_pc", 64'(bus_w.ow_pc), 64'(PC_W));
        check("w_instr", 64'(bus_w.ow_instr), 64'(mem_word(PC_W)));
        check("w_req_waiting", 64'(bus_w.ow_imem_req), 64'(1));
        cyc();
        #2; rst_w = 1'b1;
        #1;
        check("w_arst_req", 64'(bus_w.ow_imem_req), 64'(0));
        check("w_arst_addr", 64'(bus_w.ow_imem_addr), 64'(PC_W));
        check("w_arst_valid", 64'(bus_w.ow_valid), 64'(0));
        check("w_arst_pc", 64'(bus_w.ow_pc), 64'(0));
        check("w_arst_instr", 64'(bus_w.ow_instr), 64'(INSTR_NOP));
        check("w_arst_count", 64'(dbg_w.count), 64'(0));
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
